nmr_voter: RTL and testbench

NMR_VOTER -- requirements
Module: nmr_voter

---
 rtl/nmr_voter_pkg.sv | 21 ++
 rtl/nmr_majority.sv | 47 ++++
 rtl/nmr_voter.sv | 116 +++++++++++
 tb/tb_nmr_voter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nmr_voter_pkg.sv
// rtl/nmr_voter_pkg.sv - shared channel-state type and parameter limits for the NMR voter
package nmr_voter_pkg;

   typedef enum logic [1:0] {
      ST_ACTIVE   = 2'd0,
      ST_SUSPECT  = 2'd1,
      ST_DISABLED = 2'd2
   } chan_state_t;

   localparam int WIDTH_MIN        = 1;
   localparam int WIDTH_MAX        = 64;
   localparam int CHANNELS_MIN     = 3;
   localparam int CHANNELS_MAX     = 7;
   localparam int FAULT_THRESH_MIN = 1;
   localparam int FAULT_THRESH_MAX = 15;

   function automatic int cnt_width(input int thresh);
      return $clog2(thresh + 1);
   endfunction

endpackage

// File: rtl/nmr_majority.sv
// rtl/nmr_majority.sv - combinational masked bitwise majority with lowest-enabled-channel tie break
module nmr_majority import nmr_voter_pkg::*; #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 3
) (
   input  logic [CHANNELS*WIDTH-1:0] data,
   input  logic [CHANNELS-1:0]       enable,
   output logic [WIDTH-1:0]          voted
);

   logic [4:0] n_en;
   logic [4:0] ones;
   logic       tie_bit;
   logic       found;

   always_comb begin
      voted   = '0;
      n_en    = '0;
      ones    = '0;
      tie_bit = 1'b0;
      found   = 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
         n_en = n_en + 5'(enable[k]);
      end
      for (int b = 0; b < WIDTH; b++) begin
         ones    = '0;
         tie_bit = 1'b0;
         found   = 1'b0;
         for (int k = 0; k < CHANNELS; k++) begin
            if (enable[k]) begin
               ones = ones + 5'(data[k*WIDTH+b]);
               if (!found) begin
                  tie_bit = data[k*WIDTH+b];
                  found   = 1'b1;
               end
            end
         end
         // Compare 2*ones against n_en so that ties only arise on even counts.
         if ({ones, 1'b0} > {1'b0, n_en}) begin
            voted[b] = 1'b1;
         end else if ({ones, 1'b0} == {1'b0, n_en}) begin
            voted[b] = tie_bit;
         end
      end
   end

endmodule

// File: rtl/nmr_voter.sv
// rtl/nmr_voter.sv - N-modular redundancy voter with per-channel fault tracking and exclusion
module nmr_voter import nmr_voter_pkg::*; #(
   parameter int WIDTH        = 8,
   parameter int CHANNELS     = 3,
   parameter int FAULT_THRESH = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   input  logic                      clear_faults,
   output logic                      out_valid,
   output logic [WIDTH-1:0]          out_data,
   output logic [CHANNELS-1:0]       mismatch,
   output logic [CHANNELS-1:0]       chan_disabled,
   output logic                      no_quorum
);

   localparam int CNT_W = cnt_width(FAULT_THRESH);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(FAULT_THRESH);

   chan_state_t         state_q [CHANNELS];
   chan_state_t         state_d [CHANNELS];
   logic [CNT_W-1:0]    cnt_q   [CHANNELS];
   logic [CNT_W-1:0]    cnt_d   [CHANNELS];
   logic [CNT_W-1:0]    cnt_inc;
   logic [CHANNELS-1:0] enable;
   logic [CHANNELS-1:0] mismatch_d;
   logic [WIDTH-1:0]    voted;
   logic                no_quorum_d;

   always_comb begin
      enable = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         enable[k] = (state_q[k] != ST_DISABLED);
      end
   end

   assign chan_disabled = ~enable;

   nmr_majority #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) u_majority (
      .data   (in_data),
      .enable (enable),
      .voted  (voted)
   );

   always_comb begin
      mismatch_d  = '0;
      no_quorum_d = ($countones(enable) < 2);
      for (int k = 0; k < CHANNELS; k++) begin
         mismatch_d[k] = enable[k] && (in_data[k*WIDTH +: WIDTH] != voted);
      end
   end

   // Clear wins over any update the same sample would have caused.
   always_comb begin
      cnt_inc = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         state_d[k] = state_q[k];
         cnt_d[k]   = cnt_q[k];
         cnt_inc    = cnt_q[k] + CNT_ONE;
         if (clear_faults) begin
            state_d[k] = ST_ACTIVE;
            cnt_d[k]   = '0;
         end else if (in_valid) begin
            case (state_q[k])
               ST_ACTIVE: begin
                  if (mismatch_d[k]) begin
                     cnt_d[k]   = CNT_ONE;
                     state_d[k] = (CNT_ONE == CNT_LIMIT) ? ST_DISABLED : ST_SUSPECT;
                  end
               end
               ST_SUSPECT: begin
                  if (mismatch_d[k]) begin
                     cnt_d[k] = cnt_inc;
                     if (cnt_inc == CNT_LIMIT) state_d[k] = ST_DISABLED;
                  end else begin
                     cnt_d[k]   = '0;
                     state_d[k] = ST_ACTIVE;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < CHANNELS; k++) begin
            state_q[k] <= ST_ACTIVE;
            cnt_q[k]   <= '0;
         end
         out_valid <= 1'b0;
         out_data  <= '0;
         mismatch  <= '0;
         no_quorum <= 1'b0;
      end else begin
         for (int k = 0; k < CHANNELS; k++) begin
            state_q[k] <= state_d[k];
            cnt_q[k]   <= cnt_d[k];
         end
         out_valid <= in_valid;
         if (in_valid) begin
            out_data  <= voted;
            mismatch  <= mismatch_d;
            no_quorum <= no_quorum_d;
         end else begin
            mismatch  <= '0;
            no_quorum <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_nmr_voter.sv
// tb/tb_nmr_voter.sv - self-checking bench for nmr_voter (3x8 default and 5x16 instances)
module tb_nmr_voter;

   localparam int W  = 8;
   localparam int C  = 3;
   localparam int W5 = 16;
   localparam int C5 = 5;
   localparam int TH = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic             in_valid, clear_faults;
   logic [C*W-1:0]   in_data;
   logic             out_valid, no_quorum;
   logic [W-1:0]     out_data;
   logic [C-1:0]     mismatch, chan_disabled;

   logic             in5_valid, clear5;
   logic [C5*W5-1:0] in5_data;
   logic             out5_valid, nq5;
   logic [W5-1:0]    out5_data;
   logic [C5-1:0]    mm5, dis5;

   nmr_voter dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .clear_faults(clear_faults), .out_valid(out_valid), .out_data(out_data),
      .mismatch(mismatch), .chan_disabled(chan_disabled), .no_quorum(no_quorum)
   );

   nmr_voter #(.WIDTH(W5), .CHANNELS(C5), .FAULT_THRESH(TH)) dut5 (
      .clk(clk), .rst_n(rst_n), .in_valid(in5_valid), .in_data(in5_data),
      .clear_faults(clear5), .out_valid(out5_valid), .out_data(out5_data),
      .mismatch(mm5), .chan_disabled(dis5), .no_quorum(nq5)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: index 0 tracks dut, index 1 tracks dut5.
   int          fails [2][7];
   bit          dis   [2][7];
   logic [63:0] ex_data  [2];
   bit          ex_valid [2];
   logic [6:0]  ex_mm    [2];
   bit          ex_nq    [2];

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         for (int k = 0; k < 7; k++) begin
            fails[m][k] = 0;
            dis[m][k]   = 1'b0;
         end
         ex_data[m] = '0; ex_valid[m] = 1'b0; ex_mm[m] = '0; ex_nq[m] = 1'b0;
      end
   endtask

   function automatic logic [6:0] dis_vec(input int m);
      logic [6:0] v;
      for (int k = 0; k < 7; k++) v[k] = dis[m][k];
      return v;
   endfunction

   task automatic model_step(input int m, input int nch, input int w,
                             input logic [63:0] words [7], input bit v, input bit clr);
      logic [63:0] vote;
      logic [6:0]  mm;
      int n, ones, first;
      if (v) begin
         vote = '0; mm = '0; n = 0; first = -1;
         for (int k = 0; k < nch; k++) if (!dis[m][k]) begin
            n++;
            if (first < 0) first = k;
         end
         for (int b = 0; b < w; b++) begin
            ones = 0;
            for (int k = 0; k < nch; k++) if (!dis[m][k]) ones += int'(words[k][b]);
            if (2 * ones > n) vote[b] = 1'b1;
            else if (n > 0 && 2 * ones == n) vote[b] = words[first][b];
         end
         for (int k = 0; k < nch; k++) mm[k] = !dis[m][k] && (words[k] != vote);
         ex_valid[m] = 1'b1; ex_data[m] = vote; ex_mm[m] = mm; ex_nq[m] = (n < 2);
         if (!clr) begin
            for (int k = 0; k < nch; k++) if (!dis[m][k]) begin
               fails[m][k] = mm[k] ? fails[m][k] + 1 : 0;
               if (fails[m][k] >= TH) dis[m][k] = 1'b1;
            end
         end
      end else begin
         ex_valid[m] = 1'b0; ex_mm[m] = '0; ex_nq[m] = 1'b0;
      end
      if (clr) begin
         for (int k = 0; k < 7; k++) begin
            fails[m][k] = 0;
            dis[m][k]   = 1'b0;
         end
      end
   endtask

   task automatic step(input bit v, input logic [C*W-1:0] d, input bit c,
                       input bit v5, input logic [C5*W5-1:0] d5, input bit c5);
      logic [63:0] w3 [7];
      logic [63:0] w5 [7];
      in_valid = v; in_data = d; clear_faults = c;
      in5_valid = v5; in5_data = d5; clear5 = c5;
      for (int k = 0; k < 7; k++) begin
         w3[k] = '0; w5[k] = '0;
      end
      for (int k = 0; k < C; k++)  w3[k] = 64'(d[k*W +: W]);
      for (int k = 0; k < C5; k++) w5[k] = 64'(d5[k*W5 +: W5]);
      model_step(0, C, W, w3, v, c);
      model_step(1, C5, W5, w5, v5, c5);
      @(posedge clk);
      #1;
   endtask

   task automatic check_model(input string tag);
      check({tag, " out_valid"},  64'(out_valid),     64'(ex_valid[0]));
      check({tag, " out_data"},   64'(out_data),      ex_data[0]);
      check({tag, " mismatch"},   64'(mismatch),      64'(ex_mm[0]));
      check({tag, " no_quorum"},  64'(no_quorum),     64'(ex_nq[0]));
      check({tag, " disabled"},   64'(chan_disabled), 64'(dis_vec(0)));
      check({tag, " out5_valid"}, 64'(out5_valid),    64'(ex_valid[1]));
      check({tag, " out5_data"},  64'(out5_data),     ex_data[1]);
      check({tag, " mismatch5"},  64'(mm5),           64'(ex_mm[1]));
      check({tag, " no_quorum5"}, 64'(nq5),           64'(ex_nq[1]));
      check({tag, " disabled5"},  64'(dis5),          64'(dis_vec(1)));
   endtask

   typedef struct {
      logic         valid;
      logic         clear;
      logic [23:0]  data;
      logic         exp_valid;
      logic [7:0]   exp_data;
      logic [2:0]   exp_mm;
      logic         exp_nq;
      logic [2:0]   exp_dis;
   } vec_t;

   vec_t tbl [$];

   task automatic add(input logic v, input logic c, input logic [23:0] d, input logic ev,
                      input logic [7:0] ed, input logic [2:0] em, input logic en, input logic [2:0] edis);
      vec_t t;
      t.valid = v; t.clear = c; t.data = d; t.exp_valid = ev;
      t.exp_data = ed; t.exp_mm = em; t.exp_nq = en; t.exp_dis = edis;
      tbl.push_back(t);
   endtask

   initial begin
      logic [C*W-1:0]   rd;
      logic [C5*W5-1:0] rd5;
      int bad_ch, bad_ch5;

      in_valid = 0; in_data = '0; clear_faults = 0;
      in5_valid = 0; in5_data = '0; clear5 = 0;
      model_reset();

      // data fields are {ch2, ch1, ch0}
      add(1, 0, 24'h100805, 1, 8'h00, 3'b111, 0, 3'b000);
      add(1, 0, 24'h040712, 1, 8'h06, 3'b111, 0, 3'b000);
      add(1, 0, 24'h200101, 1, 8'h01, 3'b100, 0, 3'b000);
      add(0, 0, 24'h000000, 0, 8'h01, 3'b000, 0, 3'b000);
      add(0, 1, 24'h000000, 0, 8'h01, 3'b000, 0, 3'b000);
      for (int r = 0; r < 4; r++)
         add(1, 0, 24'h55AAAA, 1, 8'hAA, 3'b100, 0, (r == 3) ? 3'b100 : 3'b000);
      add(1, 0, 24'h3355AA, 1, 8'hAA, 3'b010, 0, 3'b100);
      add(0, 1, 24'h000000, 0, 8'hAA, 3'b000, 0, 3'b000);
      for (int r = 0; r < 3; r++) add(1, 0, 24'h112211, 1, 8'h11, 3'b010, 0, 3'b000);
      add(1, 0, 24'h111111, 1, 8'h11, 3'b000, 0, 3'b000);
      for (int r = 0; r < 3; r++) add(1, 0, 24'h112211, 1, 8'h11, 3'b010, 0, 3'b000);
      add(0, 1, 24'h000000, 0, 8'h11, 3'b000, 0, 3'b000);
      for (int r = 0; r < 4; r++)
         add(1, 0, 24'hF00F00, 1, 8'h00, 3'b110, 0, (r == 3) ? 3'b110 : 3'b000);
      add(1, 0, 24'h99773C, 1, 8'h3C, 3'b000, 1, 3'b110);
      add(1, 1, 24'h99773C, 1, 8'h3C, 3'b000, 1, 3'b000);
      add(1, 0, 24'h99773C, 1, 8'h3D, 3'b111, 0, 3'b000);
      add(0, 1, 24'h000000, 0, 8'h3D, 3'b000, 0, 3'b000);
      for (int r = 0; r < 4; r++)
         add(1, 0, 24'h100805, 1, 8'h00, 3'b111, 0, (r == 3) ? 3'b111 : 3'b000);
      add(1, 0, 24'h030201, 1, 8'h00, 3'b000, 1, 3'b111);

      #12;
      check("reset out_valid", 64'(out_valid), 64'd0);
      check("reset out_data", 64'(out_data), 64'd0);
      check("reset mismatch", 64'(mismatch), 64'd0);
      check("reset no_quorum", 64'(no_quorum), 64'd0);
      check("reset chan_disabled", 64'(chan_disabled), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      foreach (tbl[i]) begin
         step(tbl[i].valid, tbl[i].data, tbl[i].clear, 1'b0, '0, 1'b0);
         check($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'(tbl[i].exp_valid));
         check($sformatf("vec%0d out_data", i), 64'(out_data), 64'(tbl[i].exp_data));
         check($sformatf("vec%0d mismatch", i), 64'(mismatch), 64'(tbl[i].exp_mm));
         check($sformatf("vec%0d no_quorum", i), 64'(no_quorum), 64'(tbl[i].exp_nq));
         check($sformatf("vec%0d chan_disabled", i), 64'(chan_disabled), 64'(tbl[i].exp_dis));
      end

      // Asynchronous reset in the middle of a valid stream.
      in_valid = 1'b1; in_data = 24'h030201;
      #2;
      rst_n = 1'b0;
      #1;
      check("async out_valid", 64'(out_valid), 64'd0);
      check("async out_data", 64'(out_data), 64'd0);
      check("async mismatch", 64'(mismatch), 64'd0);
      check("async no_quorum", 64'(no_quorum), 64'd0);
      check("async chan_disabled", 64'(chan_disabled), 64'd0);
      @(posedge clk);
      #1;
      check("in-reset out_valid", 64'(out_valid), 64'd0);
      @(negedge clk);
      rst_n = 1'b1; in_valid = 1'b0; in5_valid = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      check("post-reset idle out_valid", 64'(out_valid), 64'd0);
      step(1'b1, 24'h332211, 1'b0, 1'b0, '0, 1'b0);
      check("post-reset first out_valid", 64'(out_valid), 64'd1);
      check_model("post-reset");

      step(1'b0, '0, 1'b0, 1'b1, 80'hFFFF_0000_0000_FFFF_FFFF, 1'b0);
      check("ch5 out_valid", 64'(out5_valid), 64'd1);
      check("ch5 out_data", 64'(out5_data), 64'hFFFF);
      check("ch5 mismatch", 64'(mm5), 64'b01100);
      check("ch5 no_quorum", 64'(nq5), 64'd0);

      bad_ch = 0; bad_ch5 = 0;
      for (int i = 0; i < 400; i++) begin
         logic [W-1:0]  base;
         logic [W5-1:0] base5;
         if (i % 60 == 0) begin
            bad_ch  = $urandom_range(0, C - 1);
            bad_ch5 = $urandom_range(0, C5 - 1);
         end
         base  = W'($urandom);
         base5 = W5'($urandom);
         for (int k = 0; k < C; k++)
            rd[k*W +: W] = ($urandom_range(0, 9) < ((k == bad_ch) ? 7 : 1)) ? W'($urandom) : base;
         for (int k = 0; k < C5; k++)
            rd5[k*W5 +: W5] = ($urandom_range(0, 9) < ((k == bad_ch5) ? 7 : 1)) ? W5'($urandom) : base5;
         step($urandom_range(0, 3) != 0, rd, $urandom_range(0, 49) == 0,
              $urandom_range(0, 3) != 0, rd5, $urandom_range(0, 49) == 0);
         check_model($sformatf("rnd%0d", i));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
